// File: rtl/control_pkg.sv
// Shared instruction-format definitions used by the encoder and the control decoder.
package control_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_MUL = 4'd5,
        OP_DIV = 4'd6,
        OP_XOR = 4'd7,
        OP_LW  = 4'd8,
        OP_SW  = 4'd9
    } op_e;

    localparam logic [5:0] OPC_ARITH = 6'b001010;
    localparam logic [5:0] OPC_LW    = 6'b001011;
    localparam logic [5:0] OPC_SW    = 6'b001100;

    localparam logic [5:0] FUNCT_ADD = 6'd32;
    localparam logic [5:0] FUNCT_SUB = 6'd34;
    localparam logic [5:0] FUNCT_AND = 6'd36;
    localparam logic [5:0] FUNCT_OR  = 6'd37;
    localparam logic [5:0] FUNCT_MUL = 6'd44;
    localparam logic [5:0] FUNCT_DIV = 6'd45;
    localparam logic [5:0] FUNCT_XOR = 6'd46;
    localparam logic [5:0] FUNCT_NOP = 6'd31;

    localparam logic [31:0] NOP_WORD = 32'h2800001F;

    // Register fields are 5 bits wide; the upper bank is never addressed.
    function automatic logic [4:0] reg_field(input logic [3:0] idx);
        return {1'b0, idx};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational encoder: one request's fields to a 32-bit word plus the
// register-read mask and load flag used by hazard detection.
module instr_pack
    import control_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [3:0]  rs_i,
    input  logic [3:0]  rt_i,
    input  logic [3:0]  rd_i,
    input  logic [15:0] offset_i,
    output logic [31:0] word_o,
    output logic        reads_rs_o,
    output logic        reads_rt_o,
    output logic        is_lw_o
);

    function automatic logic [5:0] arith_funct(input logic [3:0] op);
        case (op)
            OP_ADD:  return FUNCT_ADD;
            OP_SUB:  return FUNCT_SUB;
            OP_AND:  return FUNCT_AND;
            OP_OR:   return FUNCT_OR;
            OP_MUL:  return FUNCT_MUL;
            OP_DIV:  return FUNCT_DIV;
            OP_XOR:  return FUNCT_XOR;
            default: return FUNCT_NOP;
        endcase
    endfunction

    // Illegal opcodes fall through to the NOP word and read nothing.
    always_comb begin
        word_o     = NOP_WORD;
        reads_rs_o = 1'b0;
        reads_rt_o = 1'b0;
        is_lw_o    = 1'b0;
        case (op_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV, OP_XOR: begin
                word_o     = {OPC_ARITH, reg_field(rs_i), reg_field(rt_i),
                              reg_field(rd_i), 5'b0, arith_funct(op_i)};
                reads_rs_o = 1'b1;
                reads_rt_o = 1'b1;
            end
            OP_LW: begin
                word_o     = {OPC_LW, reg_field(rs_i), reg_field(rt_i), offset_i};
                reads_rs_o = 1'b1;
                is_lw_o    = 1'b1;
            end
            OP_SW: begin
                word_o     = {OPC_SW, reg_field(rs_i), reg_field(rt_i), offset_i};
                reads_rs_o = 1'b1;
                reads_rt_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction issue unit: encodes requests, inserts load-use NOP bubbles,
// holds the output word under back-pressure and counts issued words.
module instr_encoder
    import control_pkg::*;
#(
    parameter int HAZARD_NOPS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [3:0]  req_rs,
    input  logic [3:0]  req_rt,
    input  logic [3:0]  req_rd,
    input  logic [15:0] req_offset,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic        illegal_op,
    output logic [15:0] issued_count
);

    localparam logic [2:0] GAP_MAX = 3'(HAZARD_NOPS);

    typedef enum logic [1:0] {ST_ISSUE, ST_BUBBLE, ST_PEND} state_e;

    state_e      state_q;
    logic        valid_q;
    logic [31:0] word_q;
    logic        illegal_q;
    logic [15:0] count_q;
    logic        lw_valid_q;
    logic [3:0]  lw_rt_q;
    logic [2:0]  lw_gap_q;
    logic [2:0]  nop_cnt_q;

    logic [3:0]  pend_op_q, pend_rs_q, pend_rt_q, pend_rd_q;
    logic [15:0] pend_off_q;

    logic        slot_free, accept, handshake, sel_pend, hazard;
    logic [2:0]  bubbles;
    logic [3:0]  pk_op, pk_rs, pk_rt, pk_rd;
    logic [15:0] pk_off;
    logic [31:0] pk_word;
    logic        pk_reads_rs, pk_reads_rt, pk_is_lw;

    logic        load_d;
    logic [31:0] load_word_d;
    logic        load_is_lw_d;

    assign slot_free = !valid_q || instr_ready;
    assign handshake = valid_q && instr_ready;
    assign req_ready = !rst && (state_q == ST_ISSUE) && slot_free;
    assign accept    = req_valid && req_ready;

    // One encoder serves both paths: the pending request only matters in PEND.
    assign sel_pend = (state_q == ST_PEND);
    assign pk_op    = sel_pend ? pend_op_q  : req_op;
    assign pk_rs    = sel_pend ? pend_rs_q  : req_rs;
    assign pk_rt    = sel_pend ? pend_rt_q  : req_rt;
    assign pk_rd    = sel_pend ? pend_rd_q  : req_rd;
    assign pk_off   = sel_pend ? pend_off_q : req_offset;

    instr_pack u_pack (
        .op_i       (pk_op),
        .rs_i       (pk_rs),
        .rt_i       (pk_rt),
        .rd_i       (pk_rd),
        .offset_i   (pk_off),
        .word_o     (pk_word),
        .reads_rs_o (pk_reads_rs),
        .reads_rt_o (pk_reads_rt),
        .is_lw_o    (pk_is_lw)
    );

    assign hazard  = lw_valid_q && (lw_gap_q < GAP_MAX) && (lw_rt_q != 4'd0) &&
                     ((pk_reads_rs && (pk_rs == lw_rt_q)) ||
                      (pk_reads_rt && (pk_rt == lw_rt_q)));
    assign bubbles = GAP_MAX - lw_gap_q;

    always_comb begin
        load_d       = 1'b0;
        load_word_d  = NOP_WORD;
        load_is_lw_d = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                if (accept) begin
                    load_d = 1'b1;
                    if (!hazard) begin
                        load_word_d  = pk_word;
                        load_is_lw_d = pk_is_lw;
                    end
                end
            end
            ST_BUBBLE: load_d = slot_free;
            ST_PEND: begin
                load_d       = slot_free;
                load_word_d  = pk_word;
                load_is_lw_d = pk_is_lw;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ISSUE;
            valid_q    <= 1'b0;
            word_q     <= NOP_WORD;
            illegal_q  <= 1'b0;
            count_q    <= 16'd0;
            lw_valid_q <= 1'b0;
            lw_rt_q    <= 4'd0;
            lw_gap_q   <= GAP_MAX;
            nop_cnt_q  <= 3'd0;
        end else begin
            illegal_q <= accept && (req_op > 4'd9);
            if (handshake) begin
                count_q <= count_q + 16'd1;
            end

            // The gap counts every word loaded after the last LW, bubbles included.
            if (load_d) begin
                valid_q <= 1'b1;
                word_q  <= load_word_d;
                if (load_is_lw_d) begin
                    lw_valid_q <= 1'b1;
                    lw_rt_q    <= pk_rt;
                    lw_gap_q   <= 3'd0;
                end else if (lw_gap_q < GAP_MAX) begin
                    lw_gap_q <= lw_gap_q + 3'd1;
                end
            end else if (handshake) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                ST_ISSUE: begin
                    if (accept && hazard) begin
                        nop_cnt_q <= bubbles - 3'd1;
                        state_q   <= (bubbles > 3'd1) ? ST_BUBBLE : ST_PEND;
                    end
                end
                ST_BUBBLE: begin
                    if (slot_free) begin
                        nop_cnt_q <= nop_cnt_q - 3'd1;
                        if (nop_cnt_q == 3'd1) begin
                            state_q <= ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    if (slot_free) begin
                        state_q <= ST_ISSUE;
                    end
                end
                default: state_q <= ST_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept && hazard) begin
            pend_op_q  <= req_op;
            pend_rs_q  <= req_rs;
            pend_rt_q  <= req_rt;
            pend_rd_q  <= req_rd;
            pend_off_q <= req_offset;
        end
    end

    assign instr_valid  = valid_q;
    assign instruction  = word_q;
    assign illegal_op   = illegal_q;
    assign issued_count = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus random traffic, checked
// cycle by cycle against a word-stream reference model.
module tb_instr_encoder;

    localparam int H = 2;
    localparam logic [31:0] NOPW = 32'h2800001F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0, req_rs = '0, req_rt = '0, req_rd = '0;
    logic [15:0] req_offset = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic        illegal_op;
    logic [15:0] issued_count;

    always #5 clk = ~clk;

    instr_encoder #(.HAZARD_NOPS(H)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_rs       (req_rs),
        .req_rt       (req_rt),
        .req_rd       (req_rd),
        .req_offset   (req_offset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instruction  (instruction),
        .illegal_op   (illegal_op),
        .issued_count (issued_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the ordered stream of words the unit must emit.
    logic [31:0] m_q[$];
    logic [31:0] obs_q[$];
    logic        m_occ = 1'b0;
    int          m_pl = 0;
    int          m_gap = H;
    logic        m_lwv = 1'b0;
    logic [3:0]  m_lwrt = '0;
    logic [15:0] m_cnt = '0;
    logic        m_ill = 1'b0;
    logic        last_acc = 1'b0;
    int          ill_cnt = 0;
    logic        rnd_done = 1'b0;

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rs,
                                        input logic [3:0] rt, input logic [3:0] rd,
                                        input logic [15:0] off);
        logic [31:0] f;
        case (op)
            4'd1: f = 32;
            4'd2: f = 34;
            4'd3: f = 36;
            4'd4: f = 37;
            4'd5: f = 44;
            4'd6: f = 45;
            default: f = 46;
        endcase
        if (op >= 4'd1 && op <= 4'd7)
            return 32'h28000000 | (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | f;
        if (op == 4'd8)
            return 32'h2C000000 | (32'(rs) << 21) | (32'(rt) << 16) | 32'(off);
        if (op == 4'd9)
            return 32'h30000000 | (32'(rs) << 21) | (32'(rt) << 16) | 32'(off);
        return NOPW;
    endfunction

    task automatic model_push(input logic [31:0] w, input logic is_lw, input logic [3:0] rt);
        m_q.push_back(w);
        if (is_lw) begin
            m_lwv  = 1'b1;
            m_lwrt = rt;
            m_gap  = 0;
        end else if (m_gap < H) begin
            m_gap++;
        end
    endtask

    task automatic model_accept(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                                input logic [3:0] rd, input logic [15:0] off);
        logic rs_r, rt_r, haz;
        int   k;
        rs_r = (op >= 4'd1 && op <= 4'd9);
        rt_r = (op >= 4'd1 && op <= 4'd7) || (op == 4'd9);
        haz  = m_lwv && (m_gap < H) && (m_lwrt != 4'd0) &&
               ((rs_r && rs == m_lwrt) || (rt_r && rt == m_lwrt));
        k = haz ? (H - m_gap) : 0;
        for (int i = 0; i < k; i++) model_push(NOPW, 1'b0, 4'd0);
        model_push(enc(op, rs, rt, rd, off), op == 4'd8, rt);
        m_pl = k;
    endtask

    initial begin : monitor
        logic sf, exp_rr, hs, acc, ld;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_req_ready", 32'(req_ready), 32'd0);
                chk("rst_instr_valid", 32'(instr_valid), 32'd0);
                chk("rst_instruction", instruction, NOPW);
                chk("rst_illegal_op", 32'(illegal_op), 32'd0);
                chk("rst_issued_count", 32'(issued_count), 32'd0);
                m_q.delete();
                m_occ = 1'b0; m_pl = 0; m_gap = H; m_lwv = 1'b0; m_lwrt = '0;
                m_cnt = '0; m_ill = 1'b0; last_acc = 1'b0;
            end else begin
                sf     = !m_occ || instr_ready;
                exp_rr = (m_pl == 0) && sf;
                chk("req_ready", 32'(req_ready), 32'(exp_rr));
                chk("instr_valid", 32'(instr_valid), 32'(m_occ));
                if (m_occ && m_q.size() > 0) chk("instruction", instruction, m_q[0]);
                chk("illegal_op", 32'(illegal_op), 32'(m_ill));
                chk("issued_count", 32'(issued_count), 32'(m_cnt));
                if (illegal_op) ill_cnt++;
                hs  = m_occ && instr_ready;
                acc = req_valid && exp_rr;
                ld  = acc || (m_pl > 0 && sf);
                if (hs) begin
                    obs_q.push_back(instruction);
                    if (m_q.size() > 0) void'(m_q.pop_front());
                    m_cnt = m_cnt + 16'd1;
                end
                if (acc) model_accept(req_op, req_rs, req_rt, req_rd, req_offset);
                else if (m_pl > 0 && sf) m_pl--;
                m_occ    = ld ? 1'b1 : (hs ? 1'b0 : m_occ);
                m_ill    = acc && (req_op > 4'd9);
                last_acc = acc;
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                        input logic [3:0] rd, input logic [15:0] off);
        int n = 0;
        req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_offset = off;
        req_valid = 1'b1;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!last_acc && n < 60);
        req_valid = 1'b0;
        chk("send_accepted", 32'(last_acc), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((m_q.size() != 0 || m_occ) && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        chk("drain_empty", 32'(m_q.size()), 32'd0);
    endtask

    task automatic chk_obs(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3, input int len);
        logic [31:0] exp_w[4];
        exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3;
        chk({tag, "_len"}, 32'(obs_q.size()), 32'(len));
        for (int i = 0; i < len && i < obs_q.size(); i++) chk(tag, obs_q[i], exp_w[i]);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("ready_after_rst", 32'(req_ready), 32'd1);
        instr_ready = 1'b1;

        // Plain arithmetic encoding
        obs_q.delete();
        send(4'd1, 4'd1, 4'd2, 4'd3, 16'd0);
        drain();
        chk_obs("add_word", 32'h28221820, 0, 0, 0, 1);
        chk("add_count", 32'(issued_count), 32'd1);

        // Load-use hazard: two bubbles
        obs_q.delete();
        send(4'd8, 4'd1, 4'd5, 4'd0, 16'd4);
        send(4'd2, 4'd5, 4'd2, 4'd6, 16'd0);
        drain();
        chk_obs("lw_use", 32'h2C250004, NOPW, NOPW, 32'h28A23022, 4);

        // One unrelated word already in the gap leaves one bubble
        obs_q.delete();
        send(4'd8, 4'd1, 4'd5, 4'd0, 16'd4);
        send(4'd1, 4'd1, 4'd2, 4'd3, 16'd0);
        send(4'd9, 4'd2, 4'd5, 4'd0, 16'd8);
        drain();
        chk_obs("sw_gap", 32'h2C250004, 32'h28221820, NOPW, 32'h30450008, 4);

        // LW to r0 never creates a hazard
        obs_q.delete();
        send(4'd8, 4'd1, 4'd0, 4'd0, 16'd4);
        send(4'd1, 4'd0, 4'd0, 4'd3, 16'd0);
        drain();
        chk_obs("lw_r0", 32'h2C200004, 32'h28001820, 0, 0, 2);

        // Back-pressure: consumer stalls 5 cycles while requests wait
        obs_q.delete();
        instr_ready = 1'b0;
        fork
            begin
                send(4'd1, 4'd1, 4'd2, 4'd3, 16'd0);
                send(4'd2, 4'd4, 4'd5, 4'd6, 16'd0);
                send(4'd7, 4'd7, 4'd1, 4'd2, 16'd0);
            end
            begin
                repeat (5) @(posedge clk);
                #2 instr_ready = 1'b1;
            end
        join
        drain();
        chk_obs("stall", 32'h28221820, 32'h28853022, 32'h28E1102E, 0, 3);

        // Illegal opcode
        obs_q.delete();
        ill_cnt = 0;
        send(4'd12, 4'd3, 4'd4, 4'd5, 16'd0);
        drain();
        repeat (2) @(posedge clk);
        #2 chk("illegal_pulses", 32'(ill_cnt), 32'd1);
        chk_obs("illegal_word", NOPW, 0, 0, 0, 1);

        // Random traffic with random back-pressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1500; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #2;
                    end
                    send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)),
                         4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                         16'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    instr_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #2;
                end
            end
        join
        instr_ready = 1'b1;
        drain();

        // Reset while bubbling discards the pending request
        send(4'd8, 4'd1, 4'd5, 4'd0, 16'd4);
        send(4'd2, 4'd5, 4'd2, 4'd6, 16'd0);
        rst = 1'b1;
        #1 chk("rst_mid_valid", 32'(instr_valid), 32'd0);
        chk("rst_mid_word", instruction, NOPW);
        @(posedge clk); #2;
        rst = 1'b0;
        obs_q.delete();
        send(4'd1, 4'd1, 4'd2, 4'd3, 16'd0);
        drain();
        repeat (4) @(posedge clk);
        #2 chk_obs("post_rst", 32'h28221820, 0, 0, 0, 1);

        // Counter wrap after 65537 handshakes
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 65537; i++) send(4'd0, 4'd0, 4'd0, 4'd0, 16'd0);
        drain();
        chk("wrap_count", 32'(issued_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction issue unit that builds 32-bit instruction words from field-level requests and streams them to instruction memory / the control decoder. It is the producing end of the instruction format the decoder consumes. It encodes requests and inserts NOP bubbles after a load whose destination is read too soon. It also holds the output under back-pressure and counts issued words.

## Interface
- HAZARD_NOPS, 2: minimum issued words between an LW and a consumer of its rt (range 1–7).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_op  in  4  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 MUL, 6 DIV, 7 XOR, 8 LW, 9 SW; 10–15 illegal.
- req_rs, req_rt, req_rd  in  4 each  register indices.
- req_offset  in  16  LW/SW offset.
- instr_valid  out  1  instruction word present.
- instr_ready  in  1  consumer accepts when instr_valid && instr_ready.
- instruction  out  32  encoded word.
- illegal_op  out  1  one-cycle pulse when an illegal req_op is accepted.
- issued_count  out  16  number of completed output handshakes.

## Operation
- Encoding. Register fields are 5 bits: {1'b0, idx}.
  - Arithmetic: {6'b001010, rs, rt, rd, 5'b0, funct}. Funct: ADD 32, SUB 34, AND 36, OR 37, MUL 44, DIV 45, XOR 46.
  - NOP: 0x2800001F (arithmetic opcode, funct 31, all register fields 0).
  - LW: {6'b001011, rs, rt, offset}. SW: {6'b001100, rs, rt, offset}.
  - Illegal op: encoded as NOP; illegal_op pulses on the accepting edge.
- Registers read per op: arithmetic reads rs and rt; LW reads rs; SW reads rs and rt; NOP reads none.
- Load tracking.
  - lw_valid and lw_rt are set when an LW word is loaded into the output register.
  - lw_gap is cleared when an LW word is loaded. It increments on every later word loaded (NOPs included) and saturates at HAZARD_NOPS.
- Hazard condition: lw_valid && lw_gap < HAZARD_NOPS && the request reads lw_rt && lw_rt != 0.
  - Required bubbles: HAZARD_NOPS − lw_gap.
- FSM states:
  - ISSUE. req_ready = !instr_valid || instr_ready. On accept without hazard: load the encoded word.
  - On accept with hazard: latch the request into a pending register, load a NOP, set nop_cnt = bubbles − 1. Go to BUBBLE if nop_cnt > 0, else to PEND.
  - BUBBLE. req_ready = 0. Each time the output slot frees, load a NOP and decrement nop_cnt. At 0, go to PEND.
  - PEND. req_ready = 0. When the slot frees, load the pending encoded word and return to ISSUE.
- Output register.
  - instruction is held stable while instr_valid && !instr_ready.
  - instr_valid drops after a handshake if no new word is loaded in the same cycle.
  - Simultaneous handshake plus load in the same cycle gives back-to-back words at full throughput.
- issued_count increments on every output handshake and wraps 0xFFFF → 0x0000.

## Timing
- Reset values: instr_valid 0, instruction 0x2800001F, req_ready 0 while rst is high, illegal_op 0, issued_count 0, state ISSUE, lw_valid 0, lw_gap = HAZARD_NOPS, nop_cnt 0.
- req_ready is 1 in the first cycle after rst deasserts.
- Latency: a request accepted at edge N drives instruction and instr_valid after edge N (one register stage). With no back-pressure, throughput is one word per cycle.
- Hazard with k bubbles: NOPs appear in the k consecutive slots, then the dependent word. req_ready is low from the accept until the dependent word loads.
- Reset mid-operation: the pending request, remaining bubbles, and held output are discarded; all state returns to reset values immediately (asynchronous).
- req_* are sampled only on the accepting edge. Changes while req_ready = 0 have no effect.

## Structure
- Shared package control_pkg:
  - op enum.
  - opcode constants: OPC_ARITH 6'b001010, OPC_LW 6'b001011, OPC_SW 6'b001100.
  - funct constants.
  - NOP_WORD 32'h2800001F.
- This package is also imported by the decoder so both ends share one definition.
- Sub-module instr_pack: purely combinational. Inputs op and fields; outputs the word, a reads_rs/reads_rt mask, and an is_lw flag. Used for both the live request path and the pending request path.

## Test plan
- Reset, then ADD rs=1 rt=2 rd=3 → instruction 0x28221820, instr_valid high one cycle after accept, issued_count 1 after handshake.
- LW rs=1 rt=5 off=4 followed by SUB rs=5 rt=2 rd=6, HAZARD_NOPS=2, instr_ready held 1 → words 0x2C250004, 0x2800001F, 0x2800001F, 0x28A23022. req_ready is low for 2 cycles.
- LW rt=5, then unrelated ADD, then SW rs=2 rt=5 off=8 → exactly one NOP before 0x30450008. With LW rt=0, no NOP is inserted.
- instr_ready held 0 for 5 cycles with req_valid high → instruction stable, req_ready 0, no requests lost; all words in order after release.
- req_op=12 → NOP word emitted and illegal_op pulses exactly once. Separately, drive 65537 handshakes → issued_count reads 1.
- Assert rst during BUBBLE → instr_valid 0 immediately, pending SUB never emitted, first post-reset request encoded without bubbles.
